// File: rtl/pipe_rca.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rca
// Description : Pipelined ripple-carry adder/subtractor, SEG bits per stage,
//               valid/ready handshake on both sides. Optional macro
//               PIPE_RCA_SAT_EN clamps s to the signed limit on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_rca #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  // Stage k keeps WIDTH-(k+1)*SEG unconsumed operand bits and (k+1)*SEG
  // finished sum bits; all stages are packed back to back in flat buses.
  function automatic int xoff(input int k);
    return k * WIDTH - (SEG * k * (k + 1)) / 2;
  endfunction

  function automatic int soff(input int k);
    return (SEG * k * (k + 1)) / 2;
  endfunction

  localparam int XTOT = (STAGES > 1) ? xoff(STAGES - 1) : 1;
  localparam int STOT = soff(STAGES);

  logic              adv;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [XTOT-1:0]   x_q;
  logic [XTOT-1:0]   y_q;
  logic [STOT-1:0]   s_q;
  logic              ovf_q;

  assign out_valid = v_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign s         = s_q[soff(STAGES-1) +: WIDTH];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int XW = WIDTH - k * SEG;

    logic [XW-1:0]          ax;
    logic [XW-1:0]          ay;
    logic                   ci;
    logic                   vi;
    logic [SEG:0]           part;
    logic [(k+1)*SEG-1:0]   s_d;

    assign part = {1'b0, ax[SEG-1:0]} + {1'b0, ay[SEG-1:0]} + {{SEG{1'b0}}, ci};

    if (k == 0) begin : g_src
      assign ax  = x;
      assign ay  = y ^ {WIDTH{sub}};
      assign ci  = c_in ^ sub;
      assign vi  = in_valid;
      assign s_d = part[SEG-1:0];
    end else begin : g_src
      localparam int PXO = xoff(k - 1);
      localparam int PSO = soff(k - 1);
      assign ax  = x_q[PXO +: XW];
      assign ay  = y_q[PXO +: XW];
      assign ci  = c_q[k-1];
      assign vi  = v_q[k-1];
      assign s_d = {part[SEG-1:0], s_q[PSO +: k*SEG]};
    end

    if (k == STAGES - 1) begin : g_last
      localparam int SO = soff(k);
      logic             ovf_d;
      logic [WIDTH-1:0] res_d;

      // Carry into the MSB is recovered as a^b^sum at that bit position.
      assign ovf_d = ax[SEG-1] ^ ay[SEG-1] ^ part[SEG-1] ^ part[SEG];
`ifdef PIPE_RCA_SAT_EN
      assign res_d = ovf_d ? {ax[SEG-1], {(WIDTH-1){~ax[SEG-1]}}} : s_d;
`else
      assign res_d = s_d;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q[k]          <= 1'b0;
          c_q[k]          <= 1'b0;
          s_q[SO +: WIDTH] <= '0;
          ovf_q           <= 1'b0;
        end else if (adv) begin
          v_q[k]          <= vi;
          c_q[k]          <= part[SEG];
          s_q[SO +: WIDTH] <= res_d;
          ovf_q           <= ovf_d;
        end
      end
    end else begin : g_mid
      localparam int XO = xoff(k);
      localparam int SO = soff(k);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q[k]                <= 1'b0;
          c_q[k]                <= 1'b0;
          x_q[XO +: XW-SEG]     <= '0;
          y_q[XO +: XW-SEG]     <= '0;
          s_q[SO +: (k+1)*SEG]  <= '0;
        end else if (adv) begin
          v_q[k]                <= vi;
          c_q[k]                <= part[SEG];
          x_q[XO +: XW-SEG]     <= ax[XW-1:SEG];
          y_q[XO +: XW-SEG]     <= ay[XW-1:SEG];
          s_q[SO +: (k+1)*SEG]  <= s_d;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_rca.sv
`default_nettype none
// tb_pipe_rca: table vectors plus random traffic checked through a scoreboard
// queue, with hand sequences for latency, stall and mid-flight reset.
module tb_pipe_rca;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             c_in = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  pipe_rca #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    bit          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
    logic        sb;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  exp_t mon_e;
  vec_t tv[9];

  int n_chk = 0;
  int n_fail = 0;
  int n_dlv = 0;
  int cyc = 0;
  bit prev_stall = 1'b0;
  logic [15:0] ps;
  logic pc, po;

  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sbt);
    exp_t r;
    logic [16:0] t;
    logic [15:0] bb;
    bb = sbt ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {16'd0, ci ^ sbt};
    r.c = t[16];
    r.s = t[15:0];
    r.o = (a[15] == bb[15]) && (t[15] != a[15]);
`ifdef PIPE_RCA_SAT_EN
    if (r.o) r.s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    r.lat = 1'b0;
    r.acc = 0;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Monitor and scoreboard: sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (prev_stall)
        check("stall_hold", {15'd0, out_valid, s}, {15'd0, 1'b1, ps});
      if (prev_stall)
        check("stall_hold_flags", {30'd0, c_out, ovf}, {30'd0, pc, po});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_output", {15'd0, out_valid, s}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("result", {14'd0, s, c_out, ovf}, {14'd0, mon_e.s, mon_e.c, mon_e.o});
          if (mon_e.lat)
            check("latency", cyc - mon_e.acc, LAT);
          n_dlv++;
        end
      end
      if (in_valid && in_ready) begin
        mon_e = cur_exp;
        mon_e.acc = cyc;
        sb_q.push_back(mon_e);
      end
      prev_stall = out_valid && !out_ready;
      ps = s;
      pc = c_out;
      po = ovf;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", {31'd0, (sb_q.size() != 0 || out_valid)}, 32'd0);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sbt, input exp_t e);
    in_valid = 1'b1;
    x = a;
    y = b;
    c_in = ci;
    sub = sbt;
    cur_exp = e;
  endtask

  initial begin
    int acc;
    int guard;
    int dl0;
    exp_t e;

    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef PIPE_RCA_SAT_EN
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tv[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
    tv[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
`else
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif
    tv[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    tv[4] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tv[6] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tv[8] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_s", {16'd0, s}, 32'd0);
    check("reset_c_out", {31'd0, c_out}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back to back at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      e.s = tv[i].s; e.c = tv[i].c; e.o = tv[i].o; e.lat = 1'b1; e.acc = 0;
      drive(tv[i].x, tv[i].y, tv[i].ci, tv[i].sb, e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain(50);

    // Random traffic with random backpressure.
    acc = 0;
    guard = 0;
    dl0 = n_dlv;
    while (acc < 32 && guard < 2000) begin
      out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < 70) begin
        x = 16'($urandom);
        y = 16'($urandom);
        c_in = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        drive(x, y, c_in, sub, model(x, y, c_in, sub));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk); #1;
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    check("random_accepted", acc, 32);
    drain(100);
    check("random_delivered", n_dlv - dl0, 32);

    // Mid-flight reset with a stalled result at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'h1111 * 16'(i + 1), 16'h0F0F, 1'b0, 1'b0,
            model(16'h1111 * 16'(i + 1), 16'h0F0F, 1'b0, 1'b0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_s", {16'd0, s}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    e = model(16'h4000, 16'h4000, 1'b0, 1'b0);
    e.lat = 1'b1;
    drive(16'h4000, 16'h4000, 1'b0, 1'b0, e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(50);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_rca.md
# pipe_rca

Parametrised, pipelined ripple-carry adder/subtractor that extends the 4-bit full-adder chain to arbitrary width. Operands are split into SEG-bit segments, and each pipeline stage ripples one segment while the carry is registered between stages. The block uses a valid/ready handshake at both ends and sits between operand-producing logic and any result consumer that can apply backpressure. It adds subtract mode, signed-overflow detection and optional saturation, none of which the plain combinational adder has.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits rippled per pipeline stage; STAGES = WIDTH/SEG.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts operands this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- c_in  input  1  carry-in (borrow-in when sub=1, see Operation).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- c_out  output  1  carry out of MSB.
- ovf  output  1  two's-complement overflow.

## Operation
- Accept on in_valid && in_ready. Result delivered on out_valid && out_ready.
- Arithmetic: yb = y ^ {WIDTH{sub}}, ci = c_in ^ sub, and {c_out, s} = x + yb + ci, taken modulo 2^(WIDTH+1).
  - sub=1, c_in=0 gives x − y. c_out=1 means no borrow.
- ovf = carry into MSB XOR c_out.
- Stage k (0..STAGES−1) adds segment k of x and yb plus the registered carry from stage k−1; stage 0 uses ci.
- Upper-segment operands are carried forward in skew registers. Lower-segment results are carried forward in deskew registers, so all segments of s emerge together.
- Each stage has a valid bit. Data and valid advance together.
- Global advance: adv = !out_valid || out_ready. All stages shift only when adv=1. in_ready = adv.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0 stages.
- Ordering is strictly preserved. No transaction is dropped or duplicated.
- s, c_out and ovf hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, all data/carry registers 0.
  - Outputs during reset: out_valid=0, s=0, c_out=0, ovf=0. in_ready=1 (out_valid=0).
- Latency: a transaction accepted at edge N has out_valid=1 after edge N+STAGES−1. With STAGES=1, the result is registered after one edge.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: out_ready=0 with out_valid=1 gives in_ready=0 combinationally in the same cycle, and the whole pipe freezes.
- Simultaneous accept and deliver in one cycle is legal and does not stall.
- Reset mid-operation: all in-flight transactions are discarded. out_valid=0 in the same cycle rst_n falls. After release, no stale result ever appears.
- The carry chain is SEG full-adder delays per stage. Critical path ≈ SEG FA delays + register.

## Configuration
- PIPE_RCA_SAT_EN defined: on ovf=1, s is clamped to the signed limit.
  - x[WIDTH−1]=0 gives 0111…1. x[WIDTH−1]=1 gives 1000…0.
  - ovf and c_out still reflect the raw computation.
  - The clamp is applied in the final stage and adds no latency.
- PIPE_RCA_SAT_EN not defined: s wraps modulo 2^WIDTH. There is no clamp logic.

## Test plan
All scenarios use WIDTH=16, SEG=4, latency 4.
- x=0xFFFF, y=0x0001, c_in=0, sub=0 → s=0x0000, c_out=1, ovf=0; out_valid exactly 4 edges after accept.
- x=0x7FFF, y=0x0001, add → ovf=1, c_out=0.
  - Without macro: s=0x8000.
  - With PIPE_RCA_SAT_EN: s=0x7FFF.
- x=0x0005, y=0x0007, sub=1, c_in=0 → s=0xFFFE, c_out=0, ovf=0. Repeat with c_in=1 → s=0xFFFD.
- x=0x0FFF, y=0x0001 (carry crosses three stage boundaries) → s=0x1000, c_out=0.
- 32 random back-to-back transactions, out_ready random 50%, in_valid random 70% → results match the reference model in order, count 32, outputs stable during stalls, in_ready==(!out_valid||out_ready) every cycle.
- 3 transactions in flight, rst_n pulsed low mid-cycle → out_valid=0 and s=0 immediately. After release with no input, out_valid stays 0 for ≥8 cycles. The next accepted transaction completes correctly.
